// File: rtl/xor_checksum_pkg.sv
// rtl/xor_checksum_pkg.sv - shared types and default widths for the xor checksum accumulator
package xor_checksum_pkg;

    localparam int XCS_WIDTH_DEF = 8;
    localparam int XCS_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } xcs_state_t;

endpackage

// File: rtl/xor_checksum_accumulator_mux.sv
// rtl/xor_checksum_accumulator_mux.sv - 2:1 multiplexer primitive
// Ports: sel selects a1 when high, a0 when low; y is the selected input.
module mux (
    input  logic sel,
    input  logic a0,
    input  logic a1,
    output logic y
);

    assign y = sel ? a1 : a0;

endmodule

// File: rtl/xor_checksum_accumulator_xor_word.sv
// rtl/xor_checksum_accumulator_xor_word.sv - word-wide XOR built only from 2:1 muxes
// Ports: a, b operand words; y = a ^ b, combinational.
module xor_word_using_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] b_n;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        // First mux acts as an inverter on b; second picks b or ~b depending on a.
        mux u_inv (
            .sel (b[i]),
            .a0  (1'b1),
            .a1  (1'b0),
            .y   (b_n[i])
        );
        mux u_sel (
            .sel (a[i]),
            .a0  (b[i]),
            .a1  (b_n[i]),
            .y   (y[i])
        );
    end

endmodule

// File: rtl/xor_checksum_accumulator.sv
// rtl/xor_checksum_accumulator.sv - streaming per-packet XOR checksum with beat count
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   up_valid/up_ready/up_data/up_last   input beat stream
//   down_valid/down_ready          result handshake
//   down_data                      packet checksum (inverted when ODD != 0)
//   down_parity                    reduction XOR of down_data
//   down_count                     beats in packet, saturating
module xor_checksum_accumulator
    import xor_checksum_pkg::*;
#(
    parameter int WIDTH = XCS_WIDTH_DEF,
    parameter int CNT_W = XCS_CNT_W_DEF,
    parameter int ODD   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    input  logic             up_last,
    output logic             down_valid,
    input  logic             down_ready,
    output logic [WIDTH-1:0] down_data,
    output logic             down_parity,
    output logic [CNT_W-1:0] down_count
);

    localparam logic [WIDTH-1:0] ODD_MASK = {WIDTH{ODD != 0}};

    xcs_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_base, acc_next, result;
    logic [CNT_W-1:0] cnt_base, cnt_next;
    logic             accept;
    logic             new_pkt;

    // Combinational from down_ready so a held result can be replaced in the same cycle.
    assign up_ready   = (state_q != HOLD) || down_ready;
    assign accept     = up_valid && up_ready;
    assign down_valid = (state_q == HOLD);

    // Any beat accepted outside ACCUM opens a fresh packet.
    assign new_pkt  = (state_q != ACCUM);
    assign acc_base = new_pkt ? '0 : acc_q;
    assign cnt_base = new_pkt ? '0 : cnt_q;
    assign cnt_next = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
    assign result   = acc_next ^ ODD_MASK;

    xor_word_using_mux #(.WIDTH(WIDTH)) u_xor (
        .a (acc_base),
        .b (up_data),
        .y (acc_next)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = up_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                if (accept && up_last) state_d = HOLD;
            end
            HOLD: begin
                if (down_ready) begin
                    if (accept) state_d = up_last ? HOLD : ACCUM;
                    else        state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            down_data   <= '0;
            down_parity <= 1'b0;
            down_count  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                acc_q <= acc_next;
                cnt_q <= cnt_next;
                if (up_last) begin
                    down_data   <= result;
                    down_parity <= ^result;
                    down_count  <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_xor_checksum_accumulator.sv
// tb/tb_xor_checksum_accumulator.sv - self-checking bench for xor_checksum_accumulator
module tb_xor_checksum_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       up_valid;
    logic [7:0] up_data;
    logic       up_last;
    logic       down_ready;

    logic       a_up_ready, a_down_valid, a_down_parity;
    logic [7:0] a_down_data, a_down_count;
    logic       b_up_ready, b_down_valid, b_down_parity;
    logic [7:0] b_down_data;
    logic [1:0] b_down_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: words of the open packet, plus the last finished packet while presented.
    logic [7:0] pkt_q[$];
    bit         m_hold;
    logic [7:0] m_xor;
    int         m_len;

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         l;
        bit         r;
        bit         e_valid;
        logic [7:0] e_data;
        bit         e_par;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    xor_checksum_accumulator #(.WIDTH(8), .CNT_W(8), .ODD(0)) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_valid    (up_valid),
        .up_ready    (a_up_ready),
        .up_data     (up_data),
        .up_last     (up_last),
        .down_valid  (a_down_valid),
        .down_ready  (down_ready),
        .down_data   (a_down_data),
        .down_parity (a_down_parity),
        .down_count  (a_down_count)
    );

    xor_checksum_accumulator #(.WIDTH(8), .CNT_W(2), .ODD(1)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .up_valid    (up_valid),
        .up_ready    (b_up_ready),
        .up_data     (up_data),
        .up_last     (up_last),
        .down_valid  (b_down_valid),
        .down_ready  (down_ready),
        .down_data   (b_down_data),
        .down_parity (b_down_parity),
        .down_count  (b_down_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        pkt_q.delete();
        m_hold = 1'b0;
    endtask

    task automatic model_clock(input bit v, input logic [7:0] d, input bit l, input bit r);
        bit ur;
        logic [7:0] x;
        ur = !m_hold || r;
        if (m_hold && r) m_hold = 1'b0;
        if (v && ur) begin
            pkt_q.push_back(d);
            if (l) begin
                x = 8'h00;
                foreach (pkt_q[i]) x = x ^ pkt_q[i];
                m_xor  = x;
                m_len  = pkt_q.size();
                m_hold = 1'b1;
                pkt_q.delete();
            end
        end
    endtask

    task automatic check_model_outputs();
        logic [7:0] exp_b;
        chk("a_down_valid", a_down_valid, m_hold);
        chk("b_down_valid", b_down_valid, m_hold);
        if (m_hold) begin
            exp_b = ~m_xor;
            chk("a_down_data",   a_down_data,   m_xor);
            chk("a_down_parity", a_down_parity, ^m_xor);
            chk("a_down_count",  a_down_count,  (m_len > 255) ? 255 : m_len);
            chk("b_down_data",   b_down_data,   exp_b);
            chk("b_down_parity", b_down_parity, ^exp_b);
            chk("b_down_count",  b_down_count,  (m_len > 3) ? 3 : m_len);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit r);
        @(negedge clk);
        up_valid   = v;
        up_data    = d;
        up_last    = l;
        down_ready = r;
        #1;
        chk("a_up_ready", a_up_ready, !m_hold || r);
        chk("b_up_ready", b_up_ready, !m_hold || r);
        @(posedge clk);
        model_clock(v, d, l, r);
        #1;
        check_model_outputs();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_a_down_valid"},  a_down_valid,  0);
        chk({tag, "_a_down_data"},   a_down_data,   0);
        chk({tag, "_a_down_parity"}, a_down_parity, 0);
        chk({tag, "_a_down_count"},  a_down_count,  0);
        chk({tag, "_a_up_ready"},    a_up_ready,    1);
        chk({tag, "_b_down_valid"},  b_down_valid,  0);
        chk({tag, "_b_down_data"},   b_down_data,   0);
        chk({tag, "_b_down_count"},  b_down_count,  0);
    endtask

    initial begin
        logic [7:0] held_data;

        vecs[0] = '{1, 8'hA5, 1, 1, 1, 8'hA5, 0, 8'd1};
        vecs[1] = '{1, 8'h0F, 0, 1, 0, 8'h00, 0, 8'd0};
        vecs[2] = '{1, 8'hF0, 0, 1, 0, 8'h00, 0, 8'd0};
        vecs[3] = '{1, 8'h3C, 1, 1, 1, 8'hC3, 0, 8'd3};
        vecs[4] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 8'd0};
        vecs[5] = '{1, 8'h01, 1, 1, 1, 8'h01, 1, 8'd1};
        vecs[6] = '{1, 8'h02, 1, 1, 1, 8'h02, 1, 8'd1};
        vecs[7] = '{1, 8'h03, 1, 1, 1, 8'h03, 0, 8'd1};
        vecs[8] = '{0, 8'h00, 0, 1, 0, 8'h00, 0, 8'd0};

        rst_n      = 1'b0;
        up_valid   = 1'b0;
        up_data    = 8'h00;
        up_last    = 1'b0;
        down_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table: single beat, three-beat packet, return to idle, back-to-back packets.
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].r);
            chk($sformatf("vec%0d_valid", i), a_down_valid, vecs[i].e_valid);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d_data", i),   a_down_data,   vecs[i].e_data);
                chk($sformatf("vec%0d_parity", i), a_down_parity, vecs[i].e_par);
                chk($sformatf("vec%0d_count", i),  a_down_count,  vecs[i].e_cnt);
            end
        end

        // Stalled result: frozen for three cycles, then replaced by a new single beat.
        step(1, 8'h77, 1, 1);
        held_data = a_down_data;
        chk("stall_load", held_data, 8'h77);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'h99, 1, 0);
            chk($sformatf("stall%0d_data", i),  a_down_data,  8'h77);
            chk($sformatf("stall%0d_count", i), a_down_count, 1);
            chk($sformatf("stall%0d_valid", i), a_down_valid, 1);
        end
        step(1, 8'h11, 1, 1);
        chk("replace_data", a_down_data, 8'h11);
        step(0, 8'h00, 0, 1);

        // Five zero beats: inverted checksum and saturated 2-bit count on the ODD instance.
        for (int i = 0; i < 5; i++) step(1, 8'h00, (i == 4), 1);
        chk("odd_data",   b_down_data,   8'hFF);
        chk("odd_parity", b_down_parity, 0);
        chk("odd_count",  b_down_count,  3);
        chk("even_count5", a_down_count, 5);
        step(0, 8'h00, 0, 1);

        // Reset in the middle of a packet discards the partial sum.
        step(1, 8'h33, 0, 1);
        step(1, 8'h44, 0, 1);
        @(negedge clk);
        rst_n    = 1'b0;
        up_valid = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 8'h5A, 1, 1);
        chk("post_rst_data",  a_down_data,  8'h5A);
        chk("post_rst_count", a_down_count, 1);

        // Randomized traffic against the packet-level model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7), 8'($urandom), ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 9) < 6));
        end
        // Long packet to exercise saturation on both counters under the model.
        for (int i = 0; i < 260; i++) step(1, 8'($urandom), (i == 259), 1);
        step(0, 8'h00, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_checksum_accumulator.md
# xor_checksum_accumulator

Parametrised streaming XOR checksum unit: accepts a packet of WIDTH-bit words on a valid/ready input, folds them into a running XOR, and presents the packet checksum, its reduction parity, and the beat count on a registered valid/ready output. It is the sequential, multi-word successor to the single-bit mux-built XOR gate. The per-beat XOR datapath is built from 2:1 mux instances only. It sits between a packet source and a checker or framer that needs an end-of-packet integrity word.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low.
- Parameters:
  - `WIDTH`, 8: data word width, ≥1.
  - `CNT_W`, 8: beat-counter width, ≥1.
  - `ODD`, 0: 1 = checksum inverted (odd sense), 0 = plain XOR.
- Ports:
  - `clk`  in  1  rising-edge clock.
  - `rst_n`  in  1  asynchronous active-low reset.
  - `up_valid`  in  1  input beat valid.
  - `up_ready`  out  1  block accepts a beat this cycle.
  - `up_data`  in  WIDTH  input word.
  - `up_last`  in  1  final beat of packet.
  - `down_valid`  out  1  result valid.
  - `down_ready`  in  1  consumer takes result.
  - `down_data`  out  WIDTH  packet checksum.
  - `down_parity`  out  1  reduction XOR of `down_data`.
  - `down_count`  out  CNT_W  beats in packet, saturating.

## Operation
- Beat accepted when `up_valid && up_ready`. Result taken when `down_valid && down_ready`.
- Internal accumulator `acc` (WIDTH) and counter `cnt` (CNT_W).
- States:
  - IDLE: no beats held.
  - ACCUM: ≥1 beat of an open packet held.
  - HOLD: result presented.
- `up_ready = (state != HOLD) || down_ready`. This is combinational from `down_ready`, so back-to-back packets run with no bubble.
- On an accepted beat:
  - Base is 0 in IDLE or HOLD (new packet), `acc` in ACCUM.
  - `acc <= base ^ up_data`.
  - `cnt <= (base cnt) + 1`, saturating at 2^CNT_W−1. Base cnt is 0 for a new packet.
- Transitions:
  - IDLE, accept, !last → ACCUM.
  - IDLE, accept, last → HOLD.
  - ACCUM, accept, last → HOLD. ACCUM with no accept stays in ACCUM.
  - HOLD, !down_ready → HOLD. Outputs and `acc` are frozen.
  - HOLD, down_ready and accept last → HOLD with the new single-beat result.
  - HOLD, down_ready and accept !last → ACCUM.
  - HOLD, down_ready, no accept → IDLE.
- Output register, loaded on entry to HOLD:
  - `down_data = (acc ^ up_data) ^ {WIDTH{ODD}}`.
  - `down_parity = ^down_data`.
  - `down_count` = final cnt.
- `down_valid = (state == HOLD)`.
- `down_data`, `down_parity` and `down_count` hold their last value outside HOLD. They are checked only while `down_valid` is high.
- `up_data` and `up_last` are ignored when not accepted.

## Timing
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state = IDLE, `acc` = 0, `cnt` = 0.
  - `down_valid` = 0, `down_data` = 0, `down_parity` = 0, `down_count` = 0.
  - `up_ready` = 1.
- Latency: last beat accepted at edge N → `down_valid` high after edge N.
- Throughput: one beat per cycle. A one-beat packet every cycle is sustained while `down_ready` = 1.
- Reset mid-packet discards the partial `acc`. The first beat after reset starts a fresh packet.
- Counter at saturation stays at 2^CNT_W−1. It does not wrap.

## Structure
- Package `xor_checksum_pkg` holds:
  - state enum `xcs_state_t` {IDLE, ACCUM, HOLD};
  - `localparam` default widths.
- Sub-module `xor_word_using_mux #(WIDTH)`:
  - combinational per-bit XOR of two words;
  - each bit built from two `mux` instances (inverter mux plus select mux) with constants 0/1;
  - used for the accumulate path.
- The ODD inversion and the reduction parity may use plain operators.

## Test plan
- WIDTH=8, ODD=0: single beat 0xA5 with last → next cycle `down_valid`=1, `down_data`=0xA5, `down_parity`=0, `down_count`=1.
- Beats 0x0F, 0xF0, 0x3C (last on third), `down_ready`=1 → `down_data`=0xC3, `down_parity`=0, `down_count`=3. Block returns to IDLE the following cycle.
- HOLD with `down_ready`=0 for 3 cycles → `up_ready`=0 and outputs stable all 3 cycles. Raising `down_ready` together with a new last beat 0x11 → next cycle `down_data`=0x11.
- Back-to-back one-beat packets 0x01, 0x02, 0x03 with `down_ready`=1 → `down_valid` high 3 consecutive cycles carrying 0x01, 0x02, 0x03.
- ODD=1, CNT_W=2: five beats of 0x00 → `down_data`=0xFF, `down_parity`=0, `down_count`=3 (saturated).
- `rst_n` low for one cycle after two non-last beats → all outputs 0. A subsequent single beat 0x5A with last → `down_data`=0x5A, `down_count`=1.
